// File: rtl/ext_pkg.sv
// Shared definitions for the ext_pipe width extender.
// - Extension mode codes carried on in_mode.
// - Skid buffer occupancy state encoding.
package ext_pkg;

  localparam logic [1:0] EXT_ZERO = 2'd0;  // zero extension
  localparam logic [1:0] EXT_SIGN = 2'd1;  // two's complement sign extension
  localparam logic [1:0] EXT_SM   = 2'd2;  // sign-magnitude -> two's complement
  localparam logic [1:0] EXT_RSVD = 2'd3;  // reserved: result zero, err flagged

  typedef enum logic [1:0] {
    SKID_EMPTY = 2'd0,
    SKID_ONE   = 2'd1,
    SKID_FULL  = 2'd2
  } skid_state_e;

endpackage

// File: rtl/ext_pipe_skid.sv
// Two-entry skid buffer with a registered input ready.
// Ports:
//   clk, rst_n            clock, async active-low reset
//   in_valid/in_ready     upstream handshake, in_data W bits
//   out_valid/out_ready   downstream handshake, out_data W bits
//   dbg_state             current occupancy state (EMPTY/ONE/FULL)
//
// Handshake: a beat moves across an interface on a rising edge where
// valid && ready are both high. valid never depends on ready on the same
// side; once valid is high with ready low, the data holds until taken.
//
// head_q is the entry presented downstream; tail_q only holds a beat
// while FULL. in_ready is a flop fed from the next state, so out_ready
// reaches in_ready only through a register.
module skid_buf
  import ext_pkg::*;
#(
  parameter int W = 17
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data,
  output logic [1:0]   dbg_state
);

  skid_state_e  state_q, state_d;
  logic [W-1:0] head_q, head_d;
  logic [W-1:0] tail_q, tail_d;
  logic         rdy_q;
  logic         accept;
  logic         drain;

  assign in_ready  = rdy_q;
  assign out_valid = (state_q != SKID_EMPTY);
  assign out_data  = head_q;
  assign dbg_state = state_q;

  assign accept = in_valid && rdy_q;
  assign drain  = out_valid && out_ready;

  always_comb begin
    state_d = state_q;
    head_d  = head_q;
    tail_d  = tail_q;
    case (state_q)
      SKID_EMPTY: begin
        if (accept) begin
          head_d  = in_data;
          state_d = SKID_ONE;
        end
      end
      SKID_ONE: begin
        if (accept && drain) begin
          head_d = in_data;
        end else if (accept) begin
          tail_d  = in_data;
          state_d = SKID_FULL;
        end else if (drain) begin
          state_d = SKID_EMPTY;
        end
      end
      SKID_FULL: begin
        // rdy_q is low here, so only a drain can happen.
        if (drain) begin
          head_d  = tail_q;
          state_d = SKID_ONE;
        end
      end
      default: state_d = SKID_EMPTY;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= SKID_EMPTY;
      head_q  <= '0;
      tail_q  <= '0;
      rdy_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
      // Goes high on the first edge after reset release.
      rdy_q   <= (state_d != SKID_FULL);
    end
  end

endmodule

// File: rtl/ext_pipe.sv
// Streaming registered width extender (zero / sign / sign-magnitude).
// Ports:
//   clk, rst_n           clock, async active-low reset
//   in_valid/in_ready    input handshake; in_data IN_W bits, in_mode 2 bits
//   out_valid/out_ready  output handshake; out_data OUT_W bits
//   out_err              beat was issued with the reserved mode
//   beat_cnt             output handshakes, wraps at 2^16
//   dbg_state            skid buffer occupancy state
module ext_pipe
  import ext_pkg::*;
#(
  parameter int IN_W  = 8,
  parameter int OUT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [IN_W-1:0]  in_data,
  input  logic [1:0]       in_mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_W-1:0] out_data,
  output logic             out_err,
  output logic [15:0]      beat_cnt,
  output logic [1:0]       dbg_state
);

  // Built by bit fill rather than replication so OUT_W == IN_W works.
  function automatic logic [OUT_W-1:0] extend(input logic [IN_W-1:0] d,
                                              input logic [1:0]      m);
    logic [OUT_W-1:0] r;
    logic [OUT_W-1:0] mag;
    r   = '0;
    mag = '0;
    mag[IN_W-2:0] = d[IN_W-2:0];
    case (m)
      EXT_ZERO: r[IN_W-1:0] = d;
      EXT_SIGN: begin
        r = {OUT_W{d[IN_W-1]}};
        r[IN_W-1:0] = d;
      end
      // Negative zero negates a zero magnitude, which yields zero.
      EXT_SM:   r = d[IN_W-1] ? -mag : mag;
      default:  r = '0;
    endcase
    return r;
  endfunction

  logic [OUT_W:0] ext_beat;
  logic [OUT_W:0] buf_beat;
  logic [15:0]    beat_cnt_q;

  assign ext_beat = {(in_mode == EXT_RSVD), extend(in_data, in_mode)};

  skid_buf #(.W(OUT_W + 1)) u_skid (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (ext_beat),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (buf_beat),
    .dbg_state (dbg_state)
  );

  assign out_err  = buf_beat[OUT_W];
  assign out_data = buf_beat[OUT_W-1:0];
  assign beat_cnt = beat_cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      beat_cnt_q <= '0;
    end else if (out_valid && out_ready) begin
      beat_cnt_q <= beat_cnt_q + 16'd1;
    end
  end

endmodule

// File: tb/tb_ext_pipe.sv
module tb_ext_pipe;
  import ext_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- DUT 8 -> 16 ----------------
  logic        in_valid, in_ready, out_valid, out_ready, out_err;
  logic [7:0]  in_data;
  logic [1:0]  in_mode, dbg_state;
  logic [15:0] out_data, beat_cnt;

  ext_pipe #(.IN_W(8), .OUT_W(16)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_mode(in_mode),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_err(out_err), .beat_cnt(beat_cnt), .dbg_state(dbg_state)
  );

  // ---------------- DUT 8 -> 8 ----------------
  logic        in_valid8, in_ready8, out_valid8, out_ready8, out_err8;
  logic [7:0]  in_data8, out_data8;
  logic [1:0]  in_mode8, dbg_state8;
  logic [15:0] beat_cnt8;

  ext_pipe #(.IN_W(8), .OUT_W(8)) dut8 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid8), .in_ready(in_ready8), .in_data(in_data8), .in_mode(in_mode8),
    .out_valid(out_valid8), .out_ready(out_ready8), .out_data(out_data8),
    .out_err(out_err8), .beat_cnt(beat_cnt8), .dbg_state(dbg_state8)
  );

  // ---------------- scoreboard state ----------------
  int checks = 0;
  int errors = 0;
  logic [16:0] exp_q[$];
  logic [8:0]  exp8_q[$];
  int accepted = 0;
  int delivered = 0;
  logic [16:0] mon_exp;
  logic [8:0]  mon8_exp;
  logic        stall_prev = 1'b0;
  logic [16:0] stall_val;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h (t=%0t)", name, got, exp, $time);
    end
  endtask

  // Reference model for the random phase, written in integer arithmetic.
  function automatic logic [16:0] model16(input logic [1:0] m, input logic [7:0] d);
    int v;
    case (m)
      2'd0: v = int'(d);
      2'd1: v = int'($signed(d));
      2'd2: v = d[7] ? -int'(d[6:0]) : int'(d[6:0]);
      default: return {1'b1, 16'h0000};
    endcase
    return {1'b0, v[15:0]};
  endfunction

  // ---------------- monitors ----------------
  always @(negedge clk) begin
    if (!rst_n) begin
      stall_prev = 1'b0;
    end else begin
      if (stall_prev)
        check("hold_stable", {15'd0, out_valid, out_err, out_data}, {15'd0, 1'b1, stall_val});
      stall_prev = out_valid && !out_ready;
      stall_val  = {out_err, out_data};
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL out_unexpected got %h expected none", {out_err, out_data});
        end else begin
          mon_exp = exp_q.pop_front();
          check("out_beat", {15'd0, out_err, out_data}, {15'd0, mon_exp});
        end
        delivered++;
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n && out_valid8 && out_ready8) begin
      if (exp8_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL out8_unexpected got %h expected none", {out_err8, out_data8});
      end else begin
        mon8_exp = exp8_q.pop_front();
        check("out8_beat", {23'd0, out_err8, out_data8}, {23'd0, mon8_exp});
      end
    end
  end

  // ---------------- drivers ----------------
  task automatic send(input logic [1:0] m, input logic [7:0] d, input logic [16:0] e);
    int waited = 0;
    in_valid = 1'b1;
    in_mode  = m;
    in_data  = d;
    @(negedge clk);
    while (!in_ready && waited < 1000) begin
      @(negedge clk);
      waited++;
    end
    if (!in_ready) begin
      checks++;
      errors++;
      $display("FAIL send_timeout got in_ready=0 expected 1");
      in_valid = 1'b0;
      return;
    end
    exp_q.push_back(e);
    accepted++;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic send8(input logic [1:0] m, input logic [7:0] d, input logic [8:0] e);
    int waited = 0;
    in_valid8 = 1'b1;
    in_mode8  = m;
    in_data8  = d;
    @(negedge clk);
    while (!in_ready8 && waited < 1000) begin
      @(negedge clk);
      waited++;
    end
    if (!in_ready8) begin
      checks++;
      errors++;
      $display("FAIL send8_timeout got in_ready=0 expected 1");
      in_valid8 = 1'b0;
      return;
    end
    exp8_q.push_back(e);
    @(posedge clk);
    #1;
    in_valid8 = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    in_valid = 1'b0;
    in_valid8 = 1'b0;
    #2;
    exp_q.delete();
    exp8_q.delete();
    accepted = 0;
    delivered = 0;
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #3_000_000;
    $display("FAIL watchdog got timeout expected completion");
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  int t0;
  bit rnd_done;
  logic [1:0] rm;
  logic [7:0] rd;

  initial begin
    in_valid = 0; in_data = 0; in_mode = 0; out_ready = 1;
    in_valid8 = 0; in_data8 = 0; in_mode8 = 0; out_ready8 = 1;

    // Reset values while rst_n is held low.
    @(posedge clk); #1;
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_out_data", {16'd0, out_data}, 32'd0);
    check("rst_out_err", {31'd0, out_err}, 32'd0);
    check("rst_beat_cnt", {16'd0, beat_cnt}, 32'd0);
    check("rst_out_valid8", {31'd0, out_valid8}, 32'd0);
    #3 rst_n = 1'b1;
    @(posedge clk); #1;
    check("in_ready_after_rst", {31'd0, in_ready}, 32'd1);
    check("in_ready8_after_rst", {31'd0, in_ready8}, 32'd1);

    // Basic modes, one-cycle latency, back-to-back throughput.
    send(2'd1, 8'hF3, {1'b0, 16'hFFF3});
    check("latency_valid", {31'd0, out_valid}, 32'd1);
    check("latency_data", {16'd0, out_data}, 32'h0000FFF3);
    send(2'd0, 8'hF3, {1'b0, 16'h00F3});
    t0 = cyc;
    send(2'd2, 8'h85, {1'b0, 16'hFFFB});
    send(2'd2, 8'h05, {1'b0, 16'h0005});
    send(2'd2, 8'h80, {1'b0, 16'h0000});
    send(2'd3, 8'h12, {1'b1, 16'h0000});
    send(2'd1, 8'h7F, {1'b0, 16'h007F});
    check("b2b_cycles", cyc - t0, 32'd5);
    repeat (3) @(posedge clk); #1;
    check("beat_cnt_basic", {16'd0, beat_cnt}, 32'd7);
    check("basic_drained", exp_q.size(), 32'd0);

    // Pass-through build, IN_W == OUT_W.
    send8(2'd0, 8'hF3, {1'b0, 8'hF3});
    send8(2'd1, 8'hF3, {1'b0, 8'hF3});
    send8(2'd1, 8'h7F, {1'b0, 8'h7F});
    send8(2'd2, 8'h85, {1'b0, 8'hFB});
    send8(2'd2, 8'h80, {1'b0, 8'h00});
    send8(2'd3, 8'h12, {1'b1, 8'h00});
    send8(2'd0, 8'h00, {1'b0, 8'h00});
    repeat (3) @(posedge clk); #1;
    check("beat_cnt8", {16'd0, beat_cnt8}, 32'd7);

    // Mid-stream reset with two beats buffered in each DUT.
    out_ready = 0;
    out_ready8 = 0;
    send(2'd0, 8'hAA, {1'b0, 16'h00AA});
    send(2'd0, 8'hBB, {1'b0, 16'h00BB});
    send8(2'd1, 8'hC3, {1'b0, 8'hC3});
    send8(2'd1, 8'h3C, {1'b0, 8'h3C});
    check("pre_rst_state", {30'd0, dbg_state}, {30'd0, SKID_FULL});
    check("pre_rst_valid8", {31'd0, out_valid8}, 32'd1);
    rst_n = 1'b0;
    #2;
    check("midrst_out_valid", {31'd0, out_valid}, 32'd0);
    check("midrst_beat_cnt", {16'd0, beat_cnt}, 32'd0);
    check("midrst_out_valid8", {31'd0, out_valid8}, 32'd0);
    check("midrst_beat_cnt8", {16'd0, beat_cnt8}, 32'd0);
    exp_q.delete();
    exp8_q.delete();
    accepted = 0;
    delivered = 0;
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;
    out_ready = 1;
    out_ready8 = 1;
    repeat (10) @(posedge clk); #1;
    check("post_rst_no_stale", {31'd0, out_valid}, 32'd0);
    check("post_rst_no_stale8", {31'd0, out_valid8}, 32'd0);
    check("post_rst_beat_cnt", {16'd0, beat_cnt}, 32'd0);

    // Backpressure: two accepts fill the buffer, third waits.
    do_reset();
    out_ready = 0;
    fork
      begin
        send(2'd0, 8'h11, {1'b0, 16'h0011});
        send(2'd1, 8'h82, {1'b0, 16'hFF82});
        send(2'd2, 8'h83, {1'b0, 16'hFFFD});
      end
      begin
        repeat (4) @(negedge clk);
        check("bp_in_ready", {31'd0, in_ready}, 32'd0);
        check("bp_state_full", {30'd0, dbg_state}, {30'd0, SKID_FULL});
        check("bp_out_data", {16'd0, out_data}, 32'h00000011);
        repeat (3) @(negedge clk);
        check("bp_out_data_hold", {16'd0, out_data}, 32'h00000011);
        @(posedge clk); #1;
        out_ready = 1;
      end
    join
    repeat (6) @(posedge clk); #1;
    check("bp_beat_cnt", {16'd0, beat_cnt}, 32'd3);
    check("bp_delivered", delivered, 32'd3);

    // Random valid/ready against the model.
    do_reset();
    rnd_done = 0;
    fork
      begin
        for (int i = 0; i < 10000; i++) begin
          rm = 2'($urandom_range(0, 3));
          rd = 8'($urandom_range(0, 255));
          if ($urandom_range(0, 3) == 0) begin
            @(posedge clk); #1;
          end
          send(rm, rd, model16(rm, rd));
        end
        rnd_done = 1;
      end
      begin
        while (!rnd_done) begin
          @(posedge clk); #1;
          out_ready = ($urandom_range(0, 3) != 0);
        end
        out_ready = 1;
      end
    join
    begin
      int w = 0;
      while (exp_q.size() != 0 && w < 200) begin
        @(posedge clk);
        w++;
      end
      #1;
    end
    check("rnd_drained", exp_q.size(), 32'd0);
    check("rnd_delivered", delivered, accepted);
    check("rnd_beat_cnt", {16'd0, beat_cnt}, accepted & 32'h0000FFFF);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
